// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: result-select codes and the shift
// saturation helper used by both shift directions.
package alu_pkg;

  typedef enum logic [2:0] {
    SEL_MUL = 3'd0,
    SEL_DIV = 3'd1,
    SEL_MOD = 3'd2,
    SEL_AND = 3'd3,
    SEL_OR  = 3'd4,
    SEL_XOR = 3'd5,
    SEL_SHL = 3'd6,
    SEL_SHR = 3'd7
  } sel_t;

  // A shift by the full operand width or more leaves nothing but zeros.
  function automatic logic shift_saturates(input logic [31:0] amount,
                                           input int unsigned width);
    return amount >= width;
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Combinational N-bit unsigned restoring divider. A zero divisor naturally
// yields an all-ones quotient and a remainder equal to the dividend.
module alu_divider #(
  parameter int N = 4
) (
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  logic [N-1:0] rem_acc;
  logic [N:0]   trial;

  // Partial remainder always stays below the divisor, so N bits suffice
  // between steps; the trial needs one extra bit for the shifted-in digit.
  always_comb begin
    rem_acc  = '0;
    trial    = '0;
    quotient = '0;
    for (int i = N - 1; i >= 0; i--) begin
      trial = {rem_acc, dividend[i]};
      if (trial >= {1'b0, divisor}) begin
        quotient[i] = 1'b1;
        trial       = trial - {1'b0, divisor};
      end
      rem_acc = trial[N-1:0];
    end
    remainder = rem_acc;
  end

endmodule

// File: rtl/alu_unit.sv
// Parameterised unsigned ALU: every operation is computed in parallel each
// cycle, plus a button-selected result, all behind one register stage.
module alu_unit
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [2:0]     op,
  input  logic           op_sum,
  input  logic           op_subt,
  output logic [N-1:0]   result,
  output logic [N-1:0]   sum_result,
  output logic [N-1:0]   sub_result,
  output logic [N-1:0]   divi_result,
  output logic [N-1:0]   modu_result,
  output logic [N-1:0]   and_result,
  output logic [N-1:0]   or_result,
  output logic [N-1:0]   xor_result,
  output logic [N-1:0]   shift_left_result,
  output logic [2*N-1:0] multi_result,
  output logic           carry_sum,
  output logic           carry_sub
);

  logic [N:0]     sum_full;
  logic [N:0]     diff_full;
  logic [2*N-1:0] prod_full;
  logic [N-1:0]   quot_next;
  logic [N-1:0]   rem_next;
  logic [N-1:0]   and_next;
  logic [N-1:0]   or_next;
  logic [N-1:0]   xor_next;
  logic [N-1:0]   shl_next;
  logic [N-1:0]   shr_next;
  logic [N-1:0]   result_next;
  sel_t           sel;

  logic [N-1:0]   result_reg;
  logic [N-1:0]   sum_reg;
  logic [N-1:0]   sub_reg;
  logic [N-1:0]   divi_reg;
  logic [N-1:0]   modu_reg;
  logic [N-1:0]   and_reg;
  logic [N-1:0]   or_reg;
  logic [N-1:0]   xor_reg;
  logic [N-1:0]   shl_reg;
  logic [2*N-1:0] multi_reg;
  logic           carry_sum_reg;
  logic           carry_sub_reg;

  // The extra top bit of the widened difference is the borrow (a < b).
  assign sum_full  = {1'b0, a} + {1'b0, b};
  assign diff_full = {1'b0, a} - {1'b0, b};
  assign prod_full = {{N{1'b0}}, a} * {{N{1'b0}}, b};

  alu_divider #(
    .N(N)
  ) u_divider (
    .dividend (a),
    .divisor  (b),
    .quotient (quot_next),
    .remainder(rem_next)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_bitwise
    assign and_next[gi] = a[gi] & b[gi];
    assign or_next[gi]  = a[gi] | b[gi];
    assign xor_next[gi] = a[gi] ^ b[gi];
  end

  always_comb begin
    shl_next = '0;
    shr_next = '0;
    if (!shift_saturates(32'(b), N)) begin
      shl_next = a << b;
      shr_next = a >> b;
    end
  end

  // Buttons are active low, so idle buttons select the multiply low half.
  assign sel = sel_t'(~op);

  always_comb begin
    result_next = '0;
    if (op_sum) begin
      result_next = sum_full[N-1:0];
    end else if (op_subt) begin
      result_next = diff_full[N-1:0];
    end else begin
      case (sel)
        SEL_MUL: result_next = prod_full[N-1:0];
        SEL_DIV: result_next = quot_next;
        SEL_MOD: result_next = rem_next;
        SEL_AND: result_next = and_next;
        SEL_OR:  result_next = or_next;
        SEL_XOR: result_next = xor_next;
        SEL_SHL: result_next = shl_next;
        SEL_SHR: result_next = shr_next;
        default: result_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg    <= '0;
      sum_reg       <= '0;
      sub_reg       <= '0;
      divi_reg      <= '0;
      modu_reg      <= '0;
      and_reg       <= '0;
      or_reg        <= '0;
      xor_reg       <= '0;
      shl_reg       <= '0;
      multi_reg     <= '0;
      carry_sum_reg <= 1'b0;
      carry_sub_reg <= 1'b0;
    end else begin
      result_reg    <= result_next;
      sum_reg       <= sum_full[N-1:0];
      sub_reg       <= diff_full[N-1:0];
      divi_reg      <= quot_next;
      modu_reg      <= rem_next;
      and_reg       <= and_next;
      or_reg        <= or_next;
      xor_reg       <= xor_next;
      shl_reg       <= shl_next;
      multi_reg     <= prod_full;
      carry_sum_reg <= sum_full[N];
      carry_sub_reg <= diff_full[N];
    end
  end

  assign result            = result_reg;
  assign sum_result        = sum_reg;
  assign sub_result        = sub_reg;
  assign divi_result       = divi_reg;
  assign modu_result       = modu_reg;
  assign and_result        = and_reg;
  assign or_result         = or_reg;
  assign xor_result        = xor_reg;
  assign shift_left_result = shl_reg;
  assign multi_result      = multi_reg;
  assign carry_sum         = carry_sum_reg;
  assign carry_sub         = carry_sub_reg;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases followed by random
// transactions, each compared against an arithmetic reference model.
module tb_alu_unit;

  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;

  logic           clk;
  logic           rst;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2:0]     op;
  logic           op_sum;
  logic           op_subt;
  logic [N-1:0]   result;
  logic [N-1:0]   sum_result;
  logic [N-1:0]   sub_result;
  logic [N-1:0]   divi_result;
  logic [N-1:0]   modu_result;
  logic [N-1:0]   and_result;
  logic [N-1:0]   or_result;
  logic [N-1:0]   xor_result;
  logic [N-1:0]   shift_left_result;
  logic [2*N-1:0] multi_result;
  logic           carry_sum;
  logic           carry_sub;

  int n_checks = 0;
  int n_fails  = 0;

  alu_unit #(.N(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .a                (a),
    .b                (b),
    .op               (op),
    .op_sum           (op_sum),
    .op_subt          (op_subt),
    .result           (result),
    .sum_result       (sum_result),
    .sub_result       (sub_result),
    .divi_result      (divi_result),
    .modu_result      (modu_result),
    .and_result       (and_result),
    .or_result        (or_result),
    .xor_result       (xor_result),
    .shift_left_result(shift_left_result),
    .multi_result     (multi_result),
    .carry_sum        (carry_sum),
    .carry_sub        (carry_sub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: straight integer arithmetic on the operand values.
  task automatic expect_outputs(input int av, input int bv, input logic [2:0] opv,
                                input logic s, input logic t, input logic r);
    int e_sum, e_sub, e_div, e_mod, e_and, e_or, e_xor, e_shl, e_shr, e_mul, e_res;
    int e_cs, e_cb;
    int by_sel [8];
    e_sum = (av + bv) & MASK;
    e_cs  = (av + bv) > MASK ? 1 : 0;
    e_sub = (av - bv + (1 << N)) & MASK;
    e_cb  = av < bv ? 1 : 0;
    e_div = bv == 0 ? MASK : av / bv;
    e_mod = bv == 0 ? av : av % bv;
    e_and = av & bv;
    e_or  = av | bv;
    e_xor = av ^ bv;
    e_shl = bv >= N ? 0 : (av << bv) & MASK;
    e_shr = bv >= N ? 0 : av >> bv;
    e_mul = av * bv;
    by_sel = '{e_mul & MASK, e_div, e_mod, e_and, e_or, e_xor, e_shl, e_shr};
    if (s)      e_res = e_sum;
    else if (t) e_res = e_sub;
    else        e_res = by_sel[7 - int'(opv)];
    if (r) begin
      e_sum = 0; e_sub = 0; e_div = 0; e_mod = 0; e_and = 0; e_or = 0;
      e_xor = 0; e_shl = 0; e_mul = 0; e_res = 0; e_cs = 0; e_cb = 0;
    end
    check("result",    32'(result),            32'(e_res));
    check("sum",       32'(sum_result),        32'(e_sum));
    check("sub",       32'(sub_result),        32'(e_sub));
    check("div",       32'(divi_result),       32'(e_div));
    check("mod",       32'(modu_result),       32'(e_mod));
    check("and",       32'(and_result),        32'(e_and));
    check("or",        32'(or_result),         32'(e_or));
    check("xor",       32'(xor_result),        32'(e_xor));
    check("shl",       32'(shift_left_result), 32'(e_shl));
    check("mul",       32'(multi_result),      32'(e_mul));
    check("carry_sum", 32'(carry_sum),         32'(e_cs));
    check("carry_sub", 32'(carry_sub),         32'(e_cb));
  endtask

  task automatic step(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [2:0] opv,
                      input logic s, input logic t, input logic r);
    @(negedge clk);
    a = av; b = bv; op = opv; op_sum = s; op_subt = t; rst = r;
    @(posedge clk);
    #1;
    $display("txn rst=%b a=%h b=%h op=%b sum=%b subt=%b -> result=%h mul=%h cs=%b cb=%b",
             r, av, bv, opv, s, t, result, multi_result, carry_sum, carry_sub);
    expect_outputs(int'(av), int'(bv), opv, s, t, r);
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; op = 3'b111; op_sum = 1'b0; op_subt = 1'b0;

    // Reset overrides live inputs, then the sum appears one edge later.
    step(4'hF, 4'h8, 3'b111, 1'b1, 1'b0, 1'b1);
    step(4'hF, 4'h8, 3'b111, 1'b1, 1'b0, 1'b0);
    check("plan_sum_result", 32'(result), 32'h7);
    check("plan_mul_78", 32'(multi_result), 32'h78);
    step(4'hF, 4'h8, 3'b111, 1'b1, 1'b1, 1'b0);
    check("plan_sum_wins", 32'(result), 32'h7);
    step(4'hF, 4'hF, 3'b111, 1'b0, 1'b1, 1'b0);
    check("plan_sub_zero", 32'(result), 32'h0);
    check("plan_sum_E", 32'(sum_result), 32'hE);
    check("plan_mul_E1", 32'(multi_result), 32'hE1);

    for (int i = 7; i >= 0; i--) step(4'hA, 4'h2, 3'(i), 1'b0, 1'b0, 1'b0);

    step(4'h8, 4'h0, 3'b110, 1'b0, 1'b0, 1'b0);
    check("plan_div0", 32'(result), 32'hF);
    step(4'h3, 4'h9, 3'b000, 1'b0, 1'b0, 1'b0);
    check("plan_borrow", 32'(carry_sub), 32'h1);

    // Reset in the middle of activity discards that cycle's computation.
    step(4'h5, 4'h3, 3'b101, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      step(N'($urandom), N'($urandom), 3'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
